// File: rtl/eth_phy_10g_rx_prbs_check.sv
// PRBS31/PRBS9 pattern checker for the 10GBASE-R RX path. A self-synchronising feed-forward
// LFSR checks each valid word; a two-stage pipeline produces per-word bit-error counts. A lock
// FSM and a saturating error accumulator act on those counts.
module eth_phy_10g_rx_prbs_check #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter bit          INVERT       = 1'b1,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 8,
  parameter int unsigned CNT_WIDTH    = 32,
  localparam int unsigned Width       = DATA_WIDTH + HDR_WIDTH,
  localparam int unsigned HdrW        = (HDR_WIDTH > 0) ? HDR_WIDTH : 1,
  localparam int unsigned CntW        = $clog2(Width + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [HdrW-1:0]       rx_hdr,
  input  logic                  rx_valid,
  input  logic                  cfg_enable,
  input  logic                  cfg_mode,
  input  logic                  cfg_clear,
  output logic [CntW-1:0]       err_word_count,
  output logic                  err_word_valid,
  output logic [CNT_WIDTH-1:0]  err_total,
  output logic                  prbs_lock,
  output logic                  err_sticky
);

  localparam int unsigned RunMax = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int unsigned RunW   = $clog2(RunMax + 1);
  localparam int unsigned SumW   = ((CNT_WIDTH > CntW) ? CNT_WIDTH : CntW) + 1;
  localparam logic [CNT_WIDTH-1:0] TotalMax = '1;

  typedef enum logic [1:0] {StIdle, StPrime, StHunt, StLocked} state_e;

  state_e                state_d, state_q;
  logic                  mode_q;
  logic [30:0]           lfsr_d, lfsr_q;
  logic [Width-1:0]      vec_raw, vec;
  logic [Width+30:0]     ext;
  logic [Width-1:0]      err_vec;
  logic                  leave;
  logic                  s1_valid_d, s1_valid_q;
  logic [Width-1:0]      s1_err_d, s1_err_q;
  logic [CntW-1:0]       pop;
  logic                  ewv_d, ewv_q;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic [RunW-1:0]       run_d, run_q, run_inc;
  logic                  lock_d, lock_q;
  logic [SumW-1:0]       sum;
  logic                  add;
  logic [CNT_WIDTH-1:0]  total_d, total_q;
  logic                  sticky_d, sticky_q;

  if (HDR_WIDTH > 0) begin : g_hdr
    assign vec_raw = {rx_data, rx_hdr};
  end else begin : g_nohdr
    assign vec_raw = rx_data;
  end

  assign vec = INVERT ? ~vec_raw : vec_raw;

  // Checker: ext holds the 31 previous bits (oldest at index 0) followed by the current word.
  always_comb begin
    ext = '0;
    for (int i = 0; i < 31; i++) ext[30-i] = lfsr_q[i];
    ext[Width+30:31] = vec;
    err_vec = '0;
    for (int k = 0; k < Width; k++) begin
      if (cfg_mode) err_vec[k] = ext[31+k] ^ ext[22+k] ^ ext[26+k];
      else          err_vec[k] = ext[31+k] ^ ext[k] ^ ext[3+k];
    end
    lfsr_d = lfsr_q;
    if (rx_valid) begin
      for (int i = 0; i < 31; i++) lfsr_d[i] = ext[Width+30-i];
    end
  end

  // Pipeline: stage 1 captures the error vector, stage 2 its popcount. Leaving the
  // checking states flushes in-flight words so none are judged against a stale context.
  always_comb begin
    leave      = !cfg_enable || (cfg_mode != mode_q);
    s1_valid_d = rx_valid && !leave && ((state_q == StHunt) || (state_q == StLocked));
    s1_err_d   = s1_valid_d ? err_vec : s1_err_q;
    pop = '0;
    for (int k = 0; k < Width; k++) pop = pop + CntW'(s1_err_q[k]);
    ewv_d = s1_valid_q && !leave;
    cnt_d = ewv_d ? pop : cnt_q;
  end

  // Lock FSM next state; one run counter serves both HUNT and LOCKED.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    run_inc = (run_q == RunW'(RunMax)) ? run_q : run_q + 1'b1;
    if (!cfg_enable) begin
      state_d = StIdle;
      run_d   = '0;
    end else if (cfg_mode != mode_q) begin
      state_d = StPrime;
      run_d   = '0;
    end else begin
      case (state_q)
        StIdle: state_d = StPrime;
        StPrime: begin
          if (rx_valid) begin
            state_d = StHunt;
            run_d   = '0;
          end
        end
        StHunt: begin
          if (ewv_q) begin
            if (cnt_q != '0) begin
              run_d = '0;
            end else if (run_inc >= RunW'(LOCK_COUNT)) begin
              state_d = StLocked;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        StLocked: begin
          if (ewv_q) begin
            if (cnt_q == '0) begin
              run_d = '0;
            end else if (run_inc >= RunW'(UNLOCK_COUNT)) begin
              state_d = StHunt;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    lock_d = (state_d == StLocked);
  end

  // Saturating accumulator; clear beats a coincident add.
  always_comb begin
    add      = (state_q == StLocked) && ewv_q;
    sum      = SumW'(total_q) + SumW'(cnt_q);
    total_d  = total_q;
    sticky_d = sticky_q;
    if (cfg_clear) begin
      total_d  = '0;
      sticky_d = 1'b0;
    end else if (add) begin
      total_d = (sum > SumW'(TotalMax)) ? TotalMax : sum[CNT_WIDTH-1:0];
      if (cnt_q != '0) sticky_d = 1'b1;
    end
  end

  // All state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      lfsr_q     <= '1;
      s1_valid_q <= 1'b0;
      s1_err_q   <= '0;
      ewv_q      <= 1'b0;
      cnt_q      <= '0;
      run_q      <= '0;
      lock_q     <= 1'b0;
      total_q    <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= cfg_mode;
      lfsr_q     <= lfsr_d;
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      ewv_q      <= ewv_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      lock_q     <= lock_d;
      total_q    <= total_d;
      sticky_q   <= sticky_d;
    end
  end

  assign err_word_count = cnt_q;
  assign err_word_valid = ewv_q;
  assign err_total      = total_q;
  assign prbs_lock      = lock_q;
  assign err_sticky     = sticky_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_prbs_check.sv
// Directed bench: u_a is a 66-bit inverted PRBS31 checker with a 4-bit accumulator,
// u_b a 32-bit headerless PRBS9 checker fed with a gapped valid.
module tb_eth_phy_10g_rx_prbs_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_data;
  logic [1:0]  a_hdr;
  logic        a_valid, a_en, a_mode, a_clr;
  logic [6:0]  a_cnt;
  logic        a_ewv, a_lock, a_sticky;
  logic [3:0]  a_total;
  logic [31:0] b_data;
  logic [0:0]  b_hdr;
  logic        b_valid, b_en, b_mode, b_clr;
  logic [5:0]  b_cnt;
  logic        b_ewv, b_lock, b_sticky;
  logic [31:0] b_total;
  logic [30:0] ga, gb;
  int          n_cmp = 0;
  int          n_bad = 0;

  eth_phy_10g_rx_prbs_check #(
    .DATA_WIDTH(64), .HDR_WIDTH(2), .INVERT(1'b1),
    .LOCK_COUNT(4), .UNLOCK_COUNT(8), .CNT_WIDTH(4)
  ) u_a (
    .clk(clk), .rst(rst), .rx_data(a_data), .rx_hdr(a_hdr), .rx_valid(a_valid),
    .cfg_enable(a_en), .cfg_mode(a_mode), .cfg_clear(a_clr),
    .err_word_count(a_cnt), .err_word_valid(a_ewv), .err_total(a_total),
    .prbs_lock(a_lock), .err_sticky(a_sticky)
  );

  eth_phy_10g_rx_prbs_check #(
    .DATA_WIDTH(32), .HDR_WIDTH(0), .INVERT(1'b0),
    .LOCK_COUNT(4), .UNLOCK_COUNT(8), .CNT_WIDTH(32)
  ) u_b (
    .clk(clk), .rst(rst), .rx_data(b_data), .rx_hdr(b_hdr), .rx_valid(b_valid),
    .cfg_enable(b_en), .cfg_mode(b_mode), .cfg_clear(b_clr),
    .err_word_count(b_cnt), .err_word_valid(b_ewv), .err_total(b_total),
    .prbs_lock(b_lock), .err_sticky(b_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmit-side PRBS generator; g[0] is the most recent bit.
  task automatic next_word(input logic mode, input int w, inout logic [30:0] g,
                           output logic [127:0] v);
    logic nb;
    v = '0;
    for (int k = 0; k < w; k++) begin
      nb   = mode ? (g[8] ^ g[4]) : (g[30] ^ g[27]);
      v[k] = nb;
      g    = {g[29:0], nb};
    end
  endtask

  task automatic drive_a(input logic [65:0] flip);
    logic [127:0] v;
    logic [65:0]  raw;
    next_word(1'b0, 66, ga, v);
    raw    = ~(v[65:0] ^ flip);
    a_data = raw[65:2];
    a_hdr  = raw[1:0];
  endtask

  // Enable with a clean stream: first count 4 cycles later, lock after PRIME + 4 words.
  task automatic lock_a(input string tag);
    a_en    = 1'b1;
    a_valid = 1'b1;
    drive_a('0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("%s_ewv_c%0d", tag, c), a_ewv, c >= 4);
      chk($sformatf("%s_lock_c%0d", tag, c), a_lock, c >= 8);
      chk($sformatf("%s_cnt_c%0d", tag, c), a_cnt, 0);
      drive_a('0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] vb;
    int           n;
    int           exp_tot;
    rst = 1'b1;
    a_data = '0; a_hdr = '0; a_valid = 1'b0; a_en = 1'b0; a_mode = 1'b0; a_clr = 1'b0;
    b_data = '0; b_hdr = '0; b_valid = 1'b0; b_en = 1'b0; b_mode = 1'b1; b_clr = 1'b0;
    ga = 31'h2A5A1234;
    gb = 31'h000001A5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ewv", a_ewv, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_total", a_total, 0);
    chk("rst_lock", a_lock, 0);
    chk("rst_sticky", a_sticky, 0);
    chk("rst_b_lock", b_lock, 0);
    rst = 1'b0;

    lock_a("init");
    chk("init_total", a_total, 0);
    chk("init_sticky", a_sticky, 0);

    // Single flipped bit 10 -> itself plus two feed-forward echoes.
    tick(); drive_a(66'd1 << 10);
    tick(); drive_a('0);
    tick();
    chk("b10_ewv", a_ewv, 1);
    chk("b10_cnt", a_cnt, 3);
    drive_a('0);
    tick();
    chk("b10_total", a_total, 3);
    chk("b10_sticky", a_sticky, 1);
    chk("b10_lock", a_lock, 1);
    chk("b10_cnt_next", a_cnt, 0);
    drive_a('0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_total", a_total, 0);
    chk("clr_sticky", a_sticky, 0);
    chk("clr_lock", a_lock, 1);

    // Eight words with bit 0 flipped: 3 errors each, saturation at 15, unlock, relock.
    drive_a(66'd1);
    for (int j = 1; j <= 14; j++) begin
      tick();
      n = (j < 2) ? 0 : ((j - 2 > 8) ? 8 : j - 2);
      exp_tot = (3 * n > 15) ? 15 : 3 * n;
      chk($sformatf("burst_cnt_j%0d", j), a_cnt, (j >= 2 && j <= 9) ? 3 : 0);
      chk($sformatf("burst_total_j%0d", j), a_total, exp_tot);
      chk($sformatf("burst_sticky_j%0d", j), a_sticky, j >= 3);
      chk($sformatf("burst_lock_j%0d", j), a_lock, (j <= 9) || (j >= 14));
      drive_a((j <= 7) ? 66'd1 : 66'd0);
    end

    // Clear coinciding with an add discards that word's errors.
    tick(); drive_a(66'd1 << 10);
    tick(); drive_a('0);
    tick();
    chk("clradd_cnt", a_cnt, 3);
    chk("clradd_total_pre", a_total, 15);
    a_clr = 1'b1;
    drive_a('0);
    tick();
    a_clr = 1'b0;
    chk("clradd_total", a_total, 0);
    chk("clradd_sticky", a_sticky, 0);
    drive_a(66'd1 << 10);
    tick(); drive_a(66'd1 << 10);
    tick(); drive_a('0);
    tick();
    chk("prerst_ewv", a_ewv, 1);
    chk("prerst_cnt", a_cnt, 3);
    chk("prerst_total", a_total, 3);
    chk("prerst_sticky", a_sticky, 1);
    chk("prerst_lock", a_lock, 1);
    drive_a('0);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #3 rst = 1'b1;
    #1;
    chk("arst_ewv", a_ewv, 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_total", a_total, 0);
    chk("arst_lock", a_lock, 0);
    chk("arst_sticky", a_sticky, 0);
    rst = 1'b0;
    lock_a("rst");

    // Mode toggle while locked: lock drops at the next edge and the checker re-primes.
    a_mode = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("mode_ewv_c%0d", c), a_ewv, c >= 5);
      chk($sformatf("mode_lock_c%0d", c), a_lock, c >= 9);
      if (c == 1) a_mode = 1'b0;
      drive_a('0);
    end
    chk("mode_total", a_total, 0);
    a_en = 1'b0;

    // PRBS9 on a 32-bit headerless path with valid toggling; invalid cycles carry junk.
    b_en    = 1'b1;
    b_valid = 1'b0;
    b_data  = $urandom;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("p9_ewv_c%0d", c), b_ewv, (c >= 5) && (c % 2 == 1));
      chk($sformatf("p9_lock_c%0d", c), b_lock, c >= 12);
      chk($sformatf("p9_cnt_c%0d", c), b_cnt, 0);
      b_valid = (c % 2 == 1);
      if (b_valid) begin
        next_word(1'b1, 32, gb, vb);
        b_data = vb[31:0];
      end else begin
        b_data = $urandom;
      end
    end
    chk("p9_total", b_total, 0);
    chk("p9_sticky", b_sticky, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
